ps2_command_tx: RTL

PS2_COMMAND_TX -- requirements
Module: ps2_command_tx

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_command_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host command transmitter: FSM states,
// well-known keyboard command bytes and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines, plus a one-cycle
// pulse on each falling edge of the synchronized clock.
module ps2_line_sync (
  input  logic clock,
  input  logic resetn,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_prev;

  // Idle bus level is high, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_ff   <= '1;
      dat_ff   <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk};
      dat_ff   <= {dat_ff[0], ps2_dat};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync = clk_ff[1];
  assign dat_sync = dat_ff[1];
  assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter (inhibit, start, 8 data bits LSB
// first, odd parity, stop, device ACK). Optional transfer timeout: PS2_TX_TIMEOUT_EN.
module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned TIMEOUT_MS = 15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  localparam int unsigned INHIBIT_CYCLES = CLK_FREQ / 1000000 * INHIBIT_US;
  localparam int unsigned INH_W          = $clog2(INHIBIT_CYCLES + 1);

  ps2_tx_state_t state, state_n;

  logic [7:0]       shreg;
  logic             parity_bit;
  logic             cur_bit;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic             ack_ok;

  logic clk_sync, dat_sync, clk_fall;
  logic clk_low, dat_low;
  logic accept, advance, count_edge, sample_ack;
  logic to_expired;

  ps2_line_sync u_sync (
    .clock    (clock),
    .resetn   (resetn),
    .ps2_clk  (PS2_CLK),
    .ps2_dat  (PS2_DAT),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .clk_fall (clk_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      to_cnt <= '0;
    else if (accept)
      to_cnt <= '0;
    else if (state != IDLE)
      to_cnt <= to_cnt + 1'b1;
  end

  assign to_expired = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    advance    = 1'b0;
    count_edge = 1'b0;
    sample_ack = 1'b0;
    clk_low    = 1'b0;
    dat_low    = 1'b0;
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_low = 1'b1;
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          dat_low = 1'b1;
          state_n = START;
        end
      end
      START: begin
        dat_low = 1'b1;
        if (clk_fall) begin
          advance    = 1'b1;
          count_edge = 1'b1;
          state_n    = DATA;
        end
      end
      DATA: begin
        dat_low = ~cur_bit;
        if (clk_fall) begin
          advance    = 1'b1;
          count_edge = 1'b1;
          if (bit_cnt == 4'd8)
            state_n = PARITY;
        end
      end
      PARITY: begin
        dat_low = ~cur_bit;
        if (clk_fall) begin
          count_edge = 1'b1;
          state_n    = STOP;
        end
      end
      STOP: begin
        state_n = ACK;
      end
      ACK: begin
        if (clk_fall) begin
          count_edge = 1'b1;
          sample_ack = 1'b1;
          state_n    = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          tx_done  = ack_ok;
          tx_error = ~ack_ok;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Timeout wins over any in-flight completion so done/error stay exclusive.
    if (to_expired) begin
      clk_low  = 1'b0;
      dat_low  = 1'b0;
      tx_done  = 1'b0;
      tx_error = 1'b1;
      state_n  = IDLE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shreg      <= '0;
      parity_bit <= 1'b0;
      cur_bit    <= 1'b0;
      bit_cnt    <= '0;
      inh_cnt    <= '0;
      ack_ok     <= 1'b0;
    end else begin
      if (accept) begin
        shreg      <= cmd_data;
        parity_bit <= odd_parity(cmd_data);
        bit_cnt    <= '0;
        inh_cnt    <= '0;
        ack_ok     <= 1'b0;
      end
      if (state == INHIBIT)
        inh_cnt <= inh_cnt + 1'b1;
      // Edges 1-8 present data bits, edge 9 presents the parity bit.
      if (advance) begin
        cur_bit <= (bit_cnt < 4'd8) ? shreg[0] : parity_bit;
        shreg   <= {1'b0, shreg[7:1]};
      end
      if (count_edge && (bit_cnt != 4'hF))
        bit_cnt <= bit_cnt + 4'd1;
      if (sample_ack)
        ack_ok <= ~dat_sync;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign tx_busy   = (state != IDLE);

  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

endmodule
